// File: rtl/phase_sequencer_if.sv
// Bundle between the instruction-cycle sequencer and its controller/datapath.
//   master : drives start/step_mode/step/mem_busy/skip_mem/halt and observes
//            phase, phase_en, instr_done, state, timeout, instr_count.
//   slave  : the sequencer side (mirror of master).
interface phase_sequencer_if #(
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             step_mode;
    logic             step;
    logic             mem_busy;
    logic             skip_mem;
    logic             halt;
    logic [4:0]       phase;
    logic             phase_en;
    logic             instr_done;
    logic [1:0]       state;
    logic             timeout;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, step_mode, step, mem_busy, skip_mem, halt,
        input  phase, phase_en, instr_done, state, timeout, instr_count
    );

    modport slave (
        input  start, step_mode, step, mem_busy, skip_mem, halt,
        output phase, phase_en, instr_done, state, timeout, instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Sequencing controller for the one-hot 5-phase instruction cycle
// (IF, ID, EX, MEM, WB). Owns the phase register and decides each cycle
// whether the datapath advances, stalls on memory, skips MEM, pauses for
// single-step or halts. Counts retired instructions and flags memory timeouts.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : phase_sequencer_if.slave (control inputs, phase/status outputs)
// Parameters:
//   WAIT_LIMIT : consecutive memory-stall cycles that trigger a timeout (>=1)
//   CNT_W      : width of the retired-instruction counter
module phase_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    phase_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    localparam logic [4:0] PH_IF  = 5'b00001;
    localparam logic [4:0] PH_ID  = 5'b00010;
    localparam logic [4:0] PH_EX  = 5'b00100;
    localparam logic [4:0] PH_MEM = 5'b01000;
    localparam logic [4:0] PH_WB  = 5'b10000;

    localparam int               WCNT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    state_e             state_q,     state_d;
    logic [4:0]         phase_q,     phase_d;
    logic               timeout_q,   timeout_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic               halt_pend_q, halt_pend_d;
    logic               skip_pend_q, skip_pend_d;
    logic [WCNT_W-1:0]  wait_cnt_q,  wait_cnt_d;

    logic phase_legal;
    logic running;
    logic stall;
    logic advance;

    // A corrupted (non-one-hot) phase never advances; it is steered to IDLE.
    assign phase_legal = $onehot(phase_q);
    assign running     = (state_q == ST_RUN) && phase_legal;
    assign stall       = running && ((phase_q == PH_IF) || (phase_q == PH_MEM)) && bus.mem_busy;
    assign advance     = running && !stall;

    assign bus.phase_en    = advance;
    assign bus.instr_done  = advance && (phase_q == PH_WB);
    assign bus.phase       = phase_q;
    assign bus.state       = state_q;
    assign bus.timeout     = timeout_q;
    assign bus.instr_count = count_q;

    always_comb begin
        // NOTE: every next-state variable gets a default before any branch so
        // no path leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        timeout_d   = timeout_q;
        count_d     = count_q;
        halt_pend_d = halt_pend_q;
        skip_pend_d = skip_pend_q;
        wait_cnt_d  = '0;   // cleared on every non-stall cycle

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                phase_d     = '0;
                halt_pend_d = 1'b0;
                skip_pend_d = 1'b0;
                if (bus.start) begin
                    state_d = ST_RUN;
                    phase_d = PH_IF;
                    if (state_q == ST_HALTED) timeout_d = 1'b0;
                end
            end

            ST_PAUSE: begin
                phase_d = '0;
                if (bus.step || !bus.step_mode) begin
                    state_d = ST_RUN;
                    phase_d = PH_IF;
                end
            end

            ST_RUN: begin
                if (!phase_legal) begin
                    state_d     = ST_IDLE;
                    phase_d     = '0;
                    halt_pend_d = 1'b0;
                    skip_pend_d = 1'b0;
                end else if (stall) begin
                    // Timeout outranks any pending halt/skip: the instruction is abandoned.
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d     = ST_HALTED;
                        phase_d     = '0;
                        timeout_d   = 1'b1;
                        halt_pend_d = 1'b0;
                        skip_pend_d = 1'b0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                    end
                end else begin
                    case (phase_q)
                        PH_IF:  phase_d = PH_ID;
                        PH_ID:  phase_d = PH_EX;
                        PH_EX: begin
                            halt_pend_d = bus.halt;
                            skip_pend_d = bus.skip_mem;
                            phase_d     = bus.skip_mem ? PH_WB : PH_MEM;
                        end
                        PH_MEM: phase_d = PH_WB;
                        PH_WB: begin
                            count_d     = count_q + CNT_W'(1);
                            skip_pend_d = 1'b0;
                            // Halt beats single-step pause when both apply.
                            if (halt_pend_q) begin
                                state_d     = ST_HALTED;
                                phase_d     = '0;
                                halt_pend_d = 1'b0;
                            end else if (bus.step_mode) begin
                                state_d = ST_PAUSE;
                                phase_d = '0;
                            end else begin
                                phase_d = PH_IF;
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                            phase_d = '0;
                        end
                    endcase
                end
            end

            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            timeout_q   <= 1'b0;
            count_q     <= '0;
            halt_pend_q <= 1'b0;
            skip_pend_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update together
            // from values computed in the same cycle, independent of order.
            state_q     <= state_d;
            phase_q     <= phase_d;
            timeout_q   <= timeout_d;
            count_q     <= count_d;
            halt_pend_q <= halt_pend_d;
            skip_pend_q <= skip_pend_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer. Directed stimulus pushes one
// expected record per instruction (cycle count, phase order, count at WB,
// number of phase_en-low cycles); a negedge monitor pops a record on every
// instr_done and compares. Status outputs are checked directly between tests.
module tb_phase_sequencer;
    localparam logic [4:0]  PH_IF  = 5'b00001;
    localparam logic [4:0]  PH_ID  = 5'b00010;
    localparam logic [4:0]  PH_EX  = 5'b00100;
    localparam logic [4:0]  PH_MEM = 5'b01000;
    localparam logic [4:0]  PH_WB  = 5'b10000;
    localparam logic [24:0] SEQ_FULL = {PH_IF, PH_ID, PH_EX, PH_MEM, PH_WB};
    localparam logic [24:0] SEQ_SKIP = {5'b00000, PH_IF, PH_ID, PH_EX, PH_WB};

    typedef struct {
        int          cycles;
        logic [24:0] seq;
        logic [15:0] count;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    phase_sequencer_if #(.CNT_W(16)) bus ();
    phase_sequencer #(.WAIT_LIMIT(15), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t        sb[$];
    int          n_compared = 0;
    int          n_mismatch = 0;
    logic [15:0] model_count = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from an IF cycle, with if_b / mem_b stall cycles.
    task automatic do_instr(input bit skip, input bit hlt, input int if_b, input int mem_b);
        exp_t e;
        check("instr_at_if", {27'd0, bus.phase}, {27'd0, PH_IF});
        e.cycles = skip ? (4 + if_b) : (5 + if_b + mem_b);
        e.seq    = skip ? SEQ_SKIP : SEQ_FULL;
        e.count  = model_count;
        e.stalls = skip ? if_b : (if_b + mem_b);
        sb.push_back(e);
        model_count++;
        bus.mem_busy = 1'b1;
        for (int i = 0; i < if_b; i++) tick();
        bus.mem_busy = 1'b0;
        tick();                     // IF -> ID
        tick();                     // ID -> EX
        bus.skip_mem = skip;
        bus.halt     = hlt;
        tick();                     // EX -> MEM/WB
        bus.skip_mem = 1'b0;
        bus.halt     = 1'b0;
        if (!skip) begin
            bus.mem_busy = 1'b1;
            for (int i = 0; i < mem_b; i++) tick();
            bus.mem_busy = 1'b0;
            tick();                 // MEM -> WB
        end
        tick();                     // WB advance
    endtask

    // Monitor: accumulates per-instruction observations, compares on instr_done.
    int          acc_cycles = 0;
    int          acc_stalls = 0;
    logic [24:0] acc_seq    = '0;
    always @(negedge clk) begin
        if (rst || bus.state != 2'd1) begin
            acc_cycles = 0;
            acc_stalls = 0;
            acc_seq    = '0;
        end else begin
            acc_cycles++;
            if (bus.phase_en) acc_seq = {acc_seq[19:0], bus.phase};
            else              acc_stalls++;
            if (bus.instr_done) begin
                if (sb.size() == 0) begin
                    n_compared++;
                    n_mismatch++;
                    $display("FAIL unexpected_instr_done: got done with count 0x%0h expected none (t=%0t)",
                             bus.instr_count, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("instr_cycles", acc_cycles, e.cycles);
                    check("instr_phase_order", {7'd0, acc_seq}, {7'd0, e.seq});
                    check("instr_count_at_wb", {16'd0, bus.instr_count}, {16'd0, e.count});
                    check("instr_stall_cycles", acc_stalls, e.stalls);
                end
                acc_cycles = 0;
                acc_stalls = 0;
                acc_seq    = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 0; bus.step_mode = 0; bus.step = 0;
        bus.mem_busy = 0; bus.skip_mem = 0; bus.halt = 0;
        #1;
        check("rst_state",   {30'd0, bus.state},       32'd0);
        check("rst_phase",   {27'd0, bus.phase},       32'd0);
        check("rst_timeout", {31'd0, bus.timeout},     32'd0);
        check("rst_count",   {16'd0, bus.instr_count}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Three plain instructions; the third halts to stop cleanly.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("start_latency_if", {27'd0, bus.phase}, {27'd0, PH_IF});
        do_instr(0, 0, 0, 0);
        do_instr(0, 0, 0, 0);
        do_instr(0, 1, 0, 0);
        check("halt_state",  {30'd0, bus.state},       32'd3);
        check("halt_phase",  {27'd0, bus.phase},       32'd0);
        check("count_after3", {16'd0, bus.instr_count}, 32'd3);

        // Restart: skip-MEM instruction, then 3+2 memory stalls.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        do_instr(1, 0, 0, 0);
        do_instr(0, 0, 3, 2);

        // Memory stuck in MEM: timeout after 15 stall cycles.
        check("to_at_if", {27'd0, bus.phase}, {27'd0, PH_IF});
        tick(); tick(); tick();
        check("to_at_mem", {27'd0, bus.phase}, {27'd0, PH_MEM});
        bus.mem_busy = 1'b1;
        repeat (14) tick();
        check("to_still_mem_14", {27'd0, bus.phase}, {27'd0, PH_MEM});
        check("to_not_yet",      {31'd0, bus.timeout}, 32'd0);
        tick();
        check("to_state",   {30'd0, bus.state},       32'd3);
        check("to_flag",    {31'd0, bus.timeout},     32'd1);
        check("to_phase",   {27'd0, bus.phase},       32'd0);
        check("to_count",   {16'd0, bus.instr_count}, {16'd0, model_count});
        bus.mem_busy = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("to_clear",    {31'd0, bus.timeout}, 32'd0);
        check("to_restart",  {27'd0, bus.phase},   {27'd0, PH_IF});

        // Single-step: pause after WB, step resumes one instruction, halt wins.
        bus.step_mode = 1'b1;
        do_instr(0, 0, 0, 0);
        check("pause_state", {30'd0, bus.state}, 32'd2);
        check("pause_phase", {27'd0, bus.phase}, 32'd0);
        tick(); tick();
        check("pause_hold",  {30'd0, bus.state}, 32'd2);
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        check("step_to_if",  {27'd0, bus.phase}, {27'd0, PH_IF});
        do_instr(0, 1, 0, 0);
        check("halt_beats_pause", {30'd0, bus.state},       32'd3);
        check("count_after_step", {16'd0, bus.instr_count}, {16'd0, model_count});

        // Asynchronous reset in EX, between clock edges.
        bus.step_mode = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick(); tick();
        check("pre_rst_ex", {27'd0, bus.phase}, {27'd0, PH_EX});
        #2 rst = 1'b1;
        #1;
        check("arst_phase", {27'd0, bus.phase},       32'd0);
        check("arst_state", {30'd0, bus.state},       32'd0);
        check("arst_count", {16'd0, bus.instr_count}, 32'd0);
        model_count = '0;
        tick();
        rst = 1'b0;
        tick();

        // One instruction after reset restarts counting from zero.
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        do_instr(0, 1, 1, 0);
        check("post_rst_count", {16'd0, bus.instr_count}, 32'd1);
        tick();
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
